// File: rtl/clock_pkg.sv
// clock_pkg: shared state, digit-position and BCD limit definitions
// for the time-of-day edit controller.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN,
    EDIT,
    COMMIT
  } state_e;

  localparam logic [1:0] POS_M1 = 2'd0;
  localparam logic [1:0] POS_M2 = 2'd1;
  localparam logic [1:0] POS_H1 = 2'd2;
  localparam logic [1:0] POS_H2 = 2'd3;

  localparam logic [3:0] M1_MAX    = 4'd9;
  localparam logic [3:0] M2_MAX    = 4'd5;
  localparam logic [3:0] H1_MAX    = 4'd9;
  localparam logic [3:0] H1_MAX_H2 = 4'd3;
  localparam logic [3:0] H2_MAX    = 4'd2;

  // Request bit order doubles as priority: lowest index wins.
  localparam int B_C   = 0;
  localparam int B_L   = 1;
  localparam int B_R   = 2;
  localparam int B_U   = 3;
  localparam int B_D   = 4;
  localparam int B_REP = 5;

  typedef struct packed {
    logic [3:0] h2;
    logic [3:0] h1;
    logic [3:0] m2;
    logic [3:0] m1;
  } bcd_time_t;

  function automatic logic [3:0] bcd_step(
    input logic [3:0] d,
    input logic [3:0] max,
    input logic       up
  );
    if (up)
      return (d >= max) ? 4'd0 : d + 4'd1;
    else
      return (d == 4'd0 || d > max) ? max : d - 4'd1;
  endfunction

  function automatic bcd_time_t digit_step(
    input bcd_time_t  t,
    input logic [1:0] p,
    input logic       up
  );
    bcd_time_t r;
    r = t;
    unique case (p)
      POS_M1: r.m1 = bcd_step(t.m1, M1_MAX, up);
      POS_M2: r.m2 = bcd_step(t.m2, M2_MAX, up);
      POS_H1: r.h1 = bcd_step(t.h1,
                       (t.h2 == H2_MAX) ? H1_MAX_H2 : H1_MAX,
                       up);
      POS_H2: begin
        r.h2 = bcd_step(t.h2, H2_MAX, up);
        // Entering the 20s must not leave an hour like 27.
        if (r.h2 == H2_MAX && t.h1 > H1_MAX_H2)
          r.h1 = H1_MAX_H2;
      end
      default: r = t;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] onehot4(input logic [1:0] p);
    return 4'b0001 << p;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchroniser, stability counter and
// one-cycle press pulse on an accepted rising level.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync[1];
        press <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_edit_ctrl.sv
// clock_edit_ctrl: tick prescaler and RUN/EDIT/COMMIT edit sequencer.
// Define CLOCK_EDIT_AUTOREPEAT_EN for held U/D auto-repeat in EDIT.
module clock_edit_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned TICK_DIV        = 100_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_CYCLES   = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btnC,
  input  logic       btnU,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       btnD,
  input  logic [3:0] cur_h2,
  input  logic [3:0] cur_h1,
  input  logic [3:0] cur_m2,
  input  logic [3:0] cur_m1,
  output logic       tick,
  output logic       wr_en,
  output logic       sec_clear,
  output logic [3:0] wr_h2,
  output logic [3:0] wr_h1,
  output logic [3:0] wr_m2,
  output logic [3:0] wr_m1,
  output logic       edit_mode,
  output logic [1:0] pos,
  output logic [3:0] led
);

  localparam int unsigned PW = $clog2(TICK_DIV + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [4:0] raw;
  logic [4:0] lvl;
  logic [4:0] prs;
  logic [5:0] req;
  logic [5:0] grant;
  logic       rep_fire;
  logic       rep_up;

  state_e        state;
  state_e        state_nx;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_nx;
  logic [1:0]    pos_nx;
  bcd_time_t     sh;
  bcd_time_t     sh_nx;
  bcd_time_t     cur;
  bcd_time_t     wr;

  assign raw = {btnD, btnU, btnR, btnL, btnC};
  assign cur = {cur_h2, cur_h1, cur_m2, cur_m1};

  for (genvar i = 0; i < 5; i++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (raw[i]),
      .level(lvl[i]),
      .press(prs[i])
    );
  end

`ifdef CLOCK_EDIT_AUTOREPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_hold;

  assign rep_hold = (state == EDIT) && (lvl[B_U] || lvl[B_D]);
  assign rep_up   = lvl[B_U];
  assign rep_fire = rep_hold && (rep_cnt == REP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rep_cnt <= '0;
    else if (!rep_hold || prs[B_U] || prs[B_D] || rep_fire)
      rep_cnt <= '0;
    else
      rep_cnt <= rep_cnt + 1'b1;
  end
`else
  assign rep_fire = 1'b0;
  assign rep_up   = 1'b0;
`endif

  // Not every debounced level feeds logic in every build.
  logic unused_lvl;
  assign unused_lvl = ^{lvl, 32'(REPEAT_CYCLES)};

  assign req   = {rep_fire, prs};
  assign grant = req & (~req + 6'd1);

  always_comb begin
    state_nx = state;
    presc_nx = '0;
    pos_nx   = pos;
    sh_nx    = sh;
    unique case (state)
      RUN: begin
        presc_nx = (presc == PRESC_LAST) ? '0 : presc + 1'b1;
        if (grant[B_C]) begin
          state_nx = EDIT;
          presc_nx = '0;
          pos_nx   = POS_M1;
          sh_nx    = cur;
        end
      end
      EDIT: begin
        unique case (1'b1)
          grant[B_C]:   state_nx = COMMIT;
          grant[B_L]:   pos_nx = pos + 2'd1;
          grant[B_R]:   pos_nx = pos - 2'd1;
          grant[B_U]:   sh_nx = digit_step(sh, pos, 1'b1);
          grant[B_D]:   sh_nx = digit_step(sh, pos, 1'b0);
          grant[B_REP]: sh_nx = digit_step(sh, pos, rep_up);
          default:      sh_nx = sh;
        endcase
      end
      COMMIT:  state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      presc     <= '0;
      pos       <= POS_M1;
      sh        <= '0;
      tick      <= 1'b0;
      wr_en     <= 1'b0;
      sec_clear <= 1'b0;
      wr        <= '0;
      edit_mode <= 1'b0;
      led       <= '0;
    end else begin
      state     <= state_nx;
      presc     <= presc_nx;
      pos       <= pos_nx;
      sh        <= sh_nx;
      tick      <= (state_nx == RUN) &&
                   (presc_nx == PRESC_LAST);
      wr_en     <= (state_nx == COMMIT);
      sec_clear <= (state_nx == COMMIT);
      wr        <= (state_nx == COMMIT) ? sh_nx : '0;
      edit_mode <= (state_nx == EDIT);
      led       <= (state_nx == EDIT) ?
                   onehot4(pos_nx) : 4'b0000;
    end
  end

  assign wr_h2 = wr.h2;
  assign wr_h1 = wr.h1;
  assign wr_m2 = wr.m2;
  assign wr_m1 = wr.m1;

endmodule

// File: tb/tb_clock_edit_ctrl.sv
// tb_clock_edit_ctrl: random and directed button sequences checked
// against a digit-level model of the edit rules.
module tb_clock_edit_ctrl;

  localparam int TD  = 10;
  localparam int DB  = 4;
  localparam int RP  = 40;
  localparam int LAT = DB + 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btnC = 1'b0;
  logic       btnU = 1'b0;
  logic       btnL = 1'b0;
  logic       btnR = 1'b0;
  logic       btnD = 1'b0;
  logic [3:0] cur_h2 = '0;
  logic [3:0] cur_h1 = '0;
  logic [3:0] cur_m2 = '0;
  logic [3:0] cur_m1 = '0;
  logic       tick;
  logic       wr_en;
  logic       sec_clear;
  logic [3:0] wr_h2;
  logic [3:0] wr_h1;
  logic [3:0] wr_m2;
  logic [3:0] wr_m1;
  logic       edit_mode;
  logic [1:0] pos;
  logic [3:0] led;

  clock_edit_ctrl #(
    .TICK_DIV       (TD),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_CYCLES  (RP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btnC     (btnC),
    .btnU     (btnU),
    .btnL     (btnL),
    .btnR     (btnR),
    .btnD     (btnD),
    .cur_h2   (cur_h2),
    .cur_h1   (cur_h1),
    .cur_m2   (cur_m2),
    .cur_m1   (cur_m1),
    .tick     (tick),
    .wr_en    (wr_en),
    .sec_clear(sec_clear),
    .wr_h2    (wr_h2),
    .wr_h1    (wr_h1),
    .wr_m2    (wr_m2),
    .wr_m1    (wr_m1),
    .edit_mode(edit_mode),
    .pos      (pos),
    .led      (led)
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;

  // Model: digit index 0=m1, 1=m2, 2=h1, 3=h2.
  bit m_edit = 1'b0;
  int m_pos = 0;
  int m_dig[4] = '{0, 0, 0, 0};
  int c_dig[4] = '{0, 0, 0, 0};

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int lim(input int p);
    case (p)
      0:       return 10;
      1:       return 6;
      2:       return (m_dig[3] == 2) ? 4 : 10;
      default: return 3;
    endcase
  endfunction

  task automatic bump(input int dir);
    int l;
    l = lim(m_pos);
    m_dig[m_pos] = (m_dig[m_pos] + l + dir) % l;
    if (m_pos == 3 && m_dig[3] == 2 && m_dig[2] > 3)
      m_dig[2] = 3;
  endtask

  // mask bits: 4=C 3=L 2=R 1=U 0=D
  task automatic model_press(input logic [4:0] m);
    if (!m_edit) begin
      if (m[4]) begin
        m_edit = 1'b1;
        m_pos = 0;
        m_dig = c_dig;
      end
    end else if (m[4]) m_edit = 1'b0;
    else if (m[3]) m_pos = (m_pos + 1) % 4;
    else if (m[2]) m_pos = (m_pos + 3) % 4;
    else if (m[1]) bump(1);
    else if (m[0]) bump(-1);
  endtask

  task automatic set_cur(input int h2, h1, m2, m1);
    c_dig = '{m1, m2, h1, h2};
    cur_h2 = 4'(h2);
    cur_h1 = 4'(h1);
    cur_m2 = 4'(m2);
    cur_m1 = 4'(m1);
  endtask

  task automatic check_commit();
    check("wr_en", 32'(wr_en), 1);
    check("sec_clear", 32'(sec_clear), 1);
    check("wr_m1", 32'(wr_m1), m_dig[0]);
    check("wr_m2", 32'(wr_m2), m_dig[1]);
    check("wr_h1", 32'(wr_h1), m_dig[2]);
    check("wr_h2", 32'(wr_h2), m_dig[3]);
    check("tick_commit", 32'(tick), 0);
    check("edit_commit", 32'(edit_mode), 0);
    check("led_commit", 32'(led), 0);
    for (int j = 1; j <= TD; j++) begin
      @(negedge clk);
      check("wr_en_len", 32'(wr_en), 0);
      check("wr_idle", 32'({wr_h2, wr_h1, wr_m2, wr_m1}), 0);
      check("tick_post", 32'(tick), 32'(j == TD));
    end
  endtask

  task automatic push(input logic [4:0] m);
    bit was_edit;
    bit commit;
    was_edit = m_edit;
    commit = m_edit && m[4];
    {btnC, btnL, btnR, btnU, btnD} = m;
    for (int k = 1; k < LAT; k++) begin
      @(negedge clk);
      if (was_edit) check("tick_edit", 32'(tick), 0);
    end
    check("pre_edge", 32'(edit_mode), 32'(was_edit));
    @(negedge clk);
    model_press(m);
    if (commit) begin
      check_commit();
    end else begin
      check("edit_mode", 32'(edit_mode), 32'(m_edit));
      check("led", 32'(led), m_edit ? (1 << m_pos) : 0);
      if (m_edit) check("pos", 32'(pos), m_pos);
      check("wr_en_idle", 32'(wr_en), 0);
      repeat (2) @(negedge clk);
    end
    {btnC, btnL, btnR, btnU, btnD} = '0;
    repeat (DB + 4) begin
      @(negedge clk);
      if (m_edit) check("tick_edit", 32'(tick), 0);
    end
  endtask

  initial begin
    logic [4:0] m;
    int h2;
    int reps;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out", 32'({tick, wr_en, sec_clear, edit_mode}), 0);
    check("rst_wr", 32'({wr_h2, wr_h1, wr_m2, wr_m1}), 0);
    check("rst_pos", 32'(pos), 0);
    check("rst_led", 32'(led), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 35; i++) begin
      check("tick_run", 32'(tick), 32'((i % TD) == TD - 1));
      if (i % 10 == 0) check("led_run", 32'(led), 0);
      @(negedge clk);
    end

    set_cur(1, 2, 3, 0);
    push(5'b10000);
    check("led_0001", 32'(led), 32'b0001);
    for (int i = 0; i < 50; i++) begin
      check("tick_hold", 32'(tick), 0);
      @(negedge clk);
    end
    push(5'b01010);
    check("lu_pos", 32'(pos), 1);
    push(5'b10000);
    check("lu_m1", 32'(m_dig[0]), 0);

    set_cur(1, 7, 0, 9);
    push(5'b10000);
    push(5'b00010);
    push(5'b01000);
    push(5'b00001);
    push(5'b01000);
    push(5'b01000);
    push(5'b00010);
    push(5'b01000);
    check("l4_pos", 32'(pos), 0);
    {btnC, btnL, btnR, btnU, btnD} = 5'b10000;
    repeat (LAT) @(negedge clk);
    model_press(5'b10000);
    check("dir_h2", 32'(wr_h2), 2);
    check("dir_h1", 32'(wr_h1), 3);
    check("dir_m2", 32'(wr_m2), 5);
    check("dir_m1", 32'(wr_m1), 0);
    check("dir_wr", 32'(wr_en), 1);
    btnC = 1'b0;
    repeat (DB + 4) @(negedge clk);

    set_cur(2, 3, 5, 9);
    push(5'b10000);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_edit = 1'b0;
    m_pos = 0;
    for (int i = 0; i < 20; i++) begin
      check("rst_edit_wr", 32'(wr_en), 0);
      check("rst_edit_mode", 32'(edit_mode), 0);
      @(negedge clk);
    end

    set_cur(0, 4, 2, 1);
    push(5'b10000);
    btnU = 1'b1;
    repeat (LAT) @(negedge clk);
    reps = 1;
`ifdef CLOCK_EDIT_AUTOREPEAT_EN
    reps = 4;
`endif
    repeat (3 * RP + 2) @(negedge clk);
    btnU = 1'b0;
    repeat (DB + 4) @(negedge clk);
    for (int i = 0; i < reps; i++) bump(1);
    push(5'b10000);
    check("hold_m1", 32'(m_dig[0]), 32'(1 + reps));

    for (int it = 0; it < 60; it++) begin
      if (!m_edit) begin
        h2 = $urandom_range(0, 2);
        set_cur(h2, $urandom_range(0, (h2 == 2) ? 3 : 9),
                $urandom_range(0, 5), $urandom_range(0, 9));
      end
      m = 5'($urandom_range(1, 15));
      if ($urandom_range(0, m_edit ? 7 : 1) == 0) m[4] = 1'b1;
      push(m);
    end
    if (m_edit) push(5'b10000);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
